// File: rtl/weight_burst_loader.sv
// rtl/weight_burst_loader.sv - multi-beat AXI4 read engine filling NUM_BANKS-way interleaved weight BRAMs
// Optional response checking is enabled by defining WEIGHT_LOADER_RRESP_CHECK_EN.
module weight_burst_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 4096,
    parameter int BURST_LEN  = 16,
    parameter int NUM_BANKS  = 2,
    parameter int BANK_AW    = $clog2(MAX_WORDS / NUM_BANKS),
    parameter int CNT_W      = $clog2(MAX_WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_W-1:0]      num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [BANK_AW-1:0]    bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic [NUM_BANKS-1:0]  bram_we,
    output logic [NUM_BANKS-1:0]  bram_en
);

    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int BANK_SHIFT = $clog2(NUM_BANKS);
    localparam int WIDE_W     = CNT_W + 9;
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0]  BANK_MASK = CNT_W'(NUM_BANKS - 1);
    localparam logic [WIDE_W-1:0] BURST_W   = WIDE_W'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_W-1:0]      remaining;
    logic [CNT_W-1:0]      word_idx;
    logic [7:0]            beat_cnt;
    logic                  err_q;

    logic [CNT_W-1:0]      clamped;
    logic [CNT_W-1:0]      idx_next;
    logic [CNT_W-1:0]      rem_next;
    logic [NUM_BANKS-1:0]  bank_sel;
    logic                  beat_final;
    logic                  beat_bad;

    function automatic logic [7:0] burst_arlen(input logic [CNT_W-1:0] rem);
        logic [WIDE_W-1:0] rem_w;
        logic [WIDE_W-1:0] beats;
        rem_w = WIDE_W'(rem);
        beats = (rem_w > BURST_W) ? BURST_W : rem_w;
        beats = beats - WIDE_W'(1);
        return beats[7:0];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [CNT_W-1:0] idx);
        return base_q + (ADDR_WIDTH'(idx) << BYTE_SHIFT);
    endfunction

    assign clamped    = (num_words > MAX_CNT) ? MAX_CNT : num_words;
    assign idx_next   = word_idx + CNT_W'(1);
    assign rem_next   = remaining - CNT_W'(1);
    assign bank_sel   = NUM_BANKS'(1) << (word_idx & BANK_MASK);
    assign beat_final = (beat_cnt == 8'd0);

`ifdef WEIGHT_LOADER_RRESP_CHECK_EN
    // The beat counter, not rlast, is authoritative; a disagreeing rlast is a protocol error.
    assign beat_bad = (rresp != 2'b00) || (rlast != beat_final);
`else
    logic unused_resp;
    assign unused_resp = ^{rresp, rlast};
    assign beat_bad    = 1'b0;
`endif

    assign arsize  = 3'(BYTE_SHIFT);
    assign arburst = 2'b01;
    assign bram_en = bram_we;
    assign error   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base_q    <= '0;
            remaining <= '0;
            word_idx  <= '0;
            beat_cnt  <= '0;
            err_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            araddr    <= '0;
            arlen     <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            bram_we   <= '0;
        end else begin
            bram_we <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        remaining <= clamped;
                        word_idx  <= '0;
                        err_q     <= 1'b0;
                        busy      <= 1'b1;
                        if (clamped != '0) begin
                            state   <= ADDR;
                            arvalid <= 1'b1;
                            araddr  <= base_addr;
                            arlen   <= burst_arlen(clamped);
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                ADDR: begin
                    if (arready) begin
                        arvalid  <= 1'b0;
                        beat_cnt <= arlen;
                        rready   <= 1'b1;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (rvalid && rready) begin
                        if (!err_q && !beat_bad) begin
                            bram_we   <= bank_sel;
                            bram_addr <= BANK_AW'(word_idx >> BANK_SHIFT);
                            bram_din  <= rdata;
                        end
                        if (beat_bad) begin
                            err_q <= 1'b1;
                        end
                        word_idx  <= idx_next;
                        remaining <= rem_next;
                        beat_cnt  <= beat_cnt - 8'd1;
                        if (beat_final) begin
                            rready <= 1'b0;
                            if (rem_next != '0 && !err_q && !beat_bad) begin
                                state   <= ADDR;
                                arvalid <= 1'b1;
                                araddr  <= word_addr(idx_next);
                                arlen   <= burst_arlen(rem_next);
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    // A zero-length request arrives here with done low and spends one extra cycle.
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_burst_loader.sv
// tb/tb_weight_burst_loader.sv - randomized self-checking bench for weight_burst_loader
`timescale 1ns/1ps
module tb_weight_burst_loader;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXW = 4096;
    localparam int BL   = 16;
    localparam int NB   = 2;
    localparam int BAW  = $clog2(MAXW / NB);
    localparam int CW   = $clog2(MAXW + 1);

    logic           clk;
    logic           rst;
    logic           start;
    logic [AW-1:0]  base_addr;
    logic [CW-1:0]  num_words;
    logic           busy, done, error;
    logic [AW-1:0]  araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic           arvalid, arready;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast, rvalid, rready;
    logic [BAW-1:0] bram_addr;
    logic [DW-1:0]  bram_din;
    logic [NB-1:0]  bram_we, bram_en;

    weight_burst_loader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WORDS(MAXW), .BURST_LEN(BL), .NUM_BANKS(NB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
        .busy(busy), .done(done), .error(error),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we), .bram_en(bram_en)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Slave behaviour knobs and observations
    int  ar_delay    = 0;
    bit  toggle_mode = 0;
    int  err_burst   = -1;
    int  err_beat    = -1;
    int  ar_wait, r_left, r_beat, ar_cnt, beats_total, stab_viol;
    logic [31:0] r_base, last_a;
    logic [7:0]  last_l;
    bit  rready_prev, ar_prev_wait;
    logic [31:0] ar_addr_q[$];
    int          ar_len_q[$];

    // Write-side observations
    logic [31:0] mem  [NB][MAXW/NB];
    int          hits [NB][MAXW/NB];
    int wr_cnt, done_cnt, done_cyc, last_we_cyc, arv_cnt, first_arv, first_busy;
    int onehot_viol, en_viol, start_cyc;
    logic err_at_done;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] ddr_word(input logic [31:0] a);
        return (a * 32'h9E3779B9) ^ 32'hC3A50F1E;
    endfunction

    // AXI read slave backed by the ddr_word() memory model
    initial begin
        arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00; rlast = 0;
        forever begin
            bit hs;
            @(negedge clk); #1;
            if (rst) begin
                arready = 0; rvalid = 0; rlast = 0; rresp = 2'b00;
                r_left = 0; r_beat = 0; ar_wait = 0; rready_prev = 0; ar_prev_wait = 0;
            end else begin
                hs = rvalid && rready_prev;
                if (hs) begin
                    beats_total++;
                    r_beat++;
                    r_left--;
                end
                if (arready) begin
                    ar_addr_q.push_back(araddr);
                    ar_len_q.push_back(int'(arlen));
                    r_base  = araddr;
                    r_left  = int'(arlen) + 1;
                    r_beat  = 0;
                    ar_cnt++;
                    arready = 0;
                    ar_wait = 0;
                end
                if (arvalid && ar_prev_wait && (araddr !== last_a || arlen !== last_l))
                    stab_viol++;
                if (arvalid && !arready && r_left == 0) begin
                    if (ar_wait >= ar_delay) arready = 1;
                    ar_wait++;
                end
                ar_prev_wait = arvalid && !arready;
                last_a = araddr;
                last_l = arlen;
                if (r_left > 0) begin
                    if (hs || !rvalid) begin
                        rvalid = toggle_mode ? cyc[0] : ($urandom_range(0, 3) != 0);
                        rdata  = ddr_word(r_base + r_beat * 4);
                        rlast  = (r_left == 1);
                        rresp  = (ar_cnt == err_burst && r_beat == err_beat) ? 2'b10 : 2'b00;
                    end
                end else begin
                    rvalid = 0; rlast = 0; rresp = 2'b00;
                end
                rready_prev = rready;
            end
        end
    end

    // BRAM / status monitor
    initial forever begin
        int b;
        @(negedge clk); #1;
        if (bram_we !== '0) begin
            if (!$onehot(bram_we)) onehot_viol++;
            if (bram_en !== bram_we) en_viol++;
            b = 0;
            for (int k = 0; k < NB; k++) if (bram_we[k]) b = k;
            mem[b][bram_addr] = bram_din;
            hits[b][bram_addr]++;
            wr_cnt++;
            last_we_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc    = cyc;
            err_at_done = error;
        end
        if (arvalid === 1'b1) begin
            arv_cnt++;
            if (first_arv < 0) first_arv = cyc;
        end
        if (busy === 1'b1 && first_busy < 0) first_busy = cyc;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int bad_words(input logic [31:0] b, input int n);
        int bad = 0;
        for (int w = 0; w < n; w++)
            if (hits[w % NB][w / NB] != 1 || mem[w % NB][w / NB] !== ddr_word(b + w * 4)) bad++;
        return bad;
    endfunction

    function automatic int bad_ars(input logic [31:0] b, input int n);
        int idx = 0, k = 0, bad = 0, len;
        while (idx < n) begin
            len = (n - idx > BL) ? BL : n - idx;
            if (k >= ar_addr_q.size()) bad++;
            else if (ar_addr_q[k] !== b + idx * 4 || ar_len_q[k] != len - 1) bad++;
            idx += len;
            k++;
        end
        if (ar_addr_q.size() != k) bad++;
        return bad;
    endfunction

    task automatic clear_records;
        ar_addr_q.delete();
        ar_len_q.delete();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < MAXW / NB; a++) begin
                mem[b][a]  = '0;
                hits[b][a] = 0;
            end
        ar_cnt = 0; beats_total = 0; stab_viol = 0;
        wr_cnt = 0; done_cnt = 0; done_cyc = -1; last_we_cyc = -1; arv_cnt = 0;
        first_arv = -1; first_busy = -1; onehot_viol = 0; en_viol = 0; err_at_done = 1'bx;
    endtask

    task automatic pulse_start(input logic [31:0] b, input int n);
        @(negedge clk);
        base_addr = b;
        num_words = CW'(n);
        start     = 1;
        start_cyc = cyc;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            if (done_cnt > 0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic settle;
        repeat (4) @(negedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst = 1; start = 0; base_addr = '0; num_words = '0;
        repeat (3) @(negedge clk);
        #2;
        tests_run++;
        if ({busy, done, error, arvalid, rready} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: busy/done/error/arvalid/rready=%b required 00000",
                     {busy, done, error, arvalid, rready});
        end
        tests_run++;
        if (araddr !== '0 || arlen !== '0) begin
            tests_failed++;
            $display("FAIL reset_ar: araddr=%h arlen=%h required 0", araddr, arlen);
        end
        tests_run++;
        if (bram_we !== '0 || bram_en !== '0 || bram_addr !== '0 || bram_din !== '0) begin
            tests_failed++;
            $display("FAIL reset_bram: we=%b en=%b addr=%h din=%h required 0",
                     bram_we, bram_en, bram_addr, bram_din);
        end
        tests_run++;
        if (arsize !== 3'd2 || arburst !== 2'b01) begin
            tests_failed++;
            $display("FAIL reset_const: arsize=%0d arburst=%b required 2 and 01", arsize, arburst);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit ok;
        int bw, ba;
        clear_records();
        pulse_start(32'h1000, 40);
        wait_done(3000, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL basic_done: no done within budget, required one pulse");
        end
        settle();
        ba = bad_ars(32'h1000, 40);
        tests_run++;
        if (ba !== 0 || ar_addr_q.size() !== 3) begin
            tests_failed++;
            $display("FAIL basic_ars: bad=%0d count=%0d required 0 bad and 3 bursts", ba, ar_addr_q.size());
        end
        bw = bad_words(32'h1000, 40);
        tests_run++;
        if (bw !== 0 || wr_cnt !== 40) begin
            tests_failed++;
            $display("FAIL basic_words: bad=%0d writes=%0d required 0 and 40", bw, wr_cnt);
        end
        tests_run++;
        if (first_arv !== start_cyc + 1 || first_busy !== start_cyc + 1) begin
            tests_failed++;
            $display("FAIL basic_latency: arvalid at %0d busy at %0d required %0d",
                     first_arv, first_busy, start_cyc + 1);
        end
        tests_run++;
        if (done_cyc !== last_we_cyc || err_at_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done_align: done cyc %0d err %b, required cyc %0d err 0",
                     done_cyc, err_at_done, last_we_cyc);
        end
        tests_run++;
        if (done_cnt !== 1 || busy !== 1'b0 || onehot_viol !== 0 || en_viol !== 0) begin
            tests_failed++;
            $display("FAIL basic_status: done_cnt=%0d busy=%b onehot_viol=%0d en_viol=%0d required 1 0 0 0",
                     done_cnt, busy, onehot_viol, en_viol);
        end
    endtask

    task automatic test_zero_len;
        bit ok;
        clear_records();
        pulse_start(32'h5000, 0);
        wait_done(20, ok);
        tests_run++;
        if (!ok || done_cyc !== start_cyc + 2) begin
            tests_failed++;
            $display("FAIL zero_done: done at %0d required %0d", done_cyc, start_cyc + 2);
        end
        settle();
        tests_run++;
        if (arv_cnt !== 0 || wr_cnt !== 0 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL zero_activity: arvalid cycles=%0d writes=%0d done=%0d required 0 0 1",
                     arv_cnt, wr_cnt, done_cnt);
        end
        tests_run++;
        if (first_busy !== start_cyc + 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_busy: first busy %0d now %b required %0d and 0",
                     first_busy, busy, start_cyc + 1);
        end
    endtask

    task automatic test_stall;
        bit ok;
        int bw, ba;
        ar_delay = 5; toggle_mode = 1;
        clear_records();
        pulse_start(32'h2000, 20);
        wait_done(2000, ok);
        settle();
        ar_delay = 0; toggle_mode = 0;
        tests_run++;
        if (!ok || stab_viol !== 0) begin
            tests_failed++;
            $display("FAIL stall_ar_stable: done=%0b changes=%0d required done and 0 changes", ok, stab_viol);
        end
        bw = bad_words(32'h2000, 20);
        ba = bad_ars(32'h2000, 20);
        tests_run++;
        if (bw !== 0 || wr_cnt !== 20 || ba !== 0) begin
            tests_failed++;
            $display("FAIL stall_data: bad words=%0d writes=%0d bad ars=%0d required 0 20 0", bw, wr_cnt, ba);
        end
    endtask

    task automatic test_clamp;
        bit ok;
        int bw, ba;
        clear_records();
        pulse_start(32'h0, 5000);
        repeat (40) @(negedge clk);
        pulse_start(32'h9000, 3);
        wait_done(30000, ok);
        settle();
        bw = bad_words(32'h0, MAXW);
        ba = bad_ars(32'h0, MAXW);
        tests_run++;
        if (!ok || wr_cnt !== MAXW || bw !== 0) begin
            tests_failed++;
            $display("FAIL clamp_words: done=%0b writes=%0d bad=%0d required 1 %0d 0", ok, wr_cnt, bw, MAXW);
        end
        tests_run++;
        if (ba !== 0 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL clamp_ignore_start: bad ars=%0d done=%0d required 0 and 1", ba, done_cnt);
        end
    endtask

    task automatic test_reset_mid;
        bit ok, reached;
        int bw, ba;
        clear_records();
        pulse_start(32'h3000, 40);
        reached = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #2;
            if (beats_total >= 18) begin
                reached = 1;
                break;
            end
        end
        tests_run++;
        if (!reached) begin
            tests_failed++;
            $display("FAIL rstmid_reach: beats=%0d required 18", beats_total);
        end
        rst = 1;
        @(negedge clk); #2;
        tests_run++;
        if ({busy, done, error, arvalid, rready} !== 5'b0 || bram_we !== '0 ||
            araddr !== '0 || arlen !== '0 || bram_addr !== '0 || bram_din !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: ctrl=%b we=%b araddr=%h arlen=%h addr=%h din=%h required all 0",
                     {busy, done, error, arvalid, rready}, bram_we, araddr, arlen, bram_addr, bram_din);
        end
        rst = 0;
        @(negedge clk);
        clear_records();
        pulse_start(32'h3400, 8);
        wait_done(500, ok);
        settle();
        bw = bad_words(32'h3400, 8);
        ba = bad_ars(32'h3400, 8);
        tests_run++;
        if (!ok || bw !== 0 || wr_cnt !== 8 || ba !== 0 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL rstmid_restart: done=%0b bad=%0d writes=%0d bad ars=%0d dones=%0d required 1 0 8 0 1",
                     ok, bw, wr_cnt, ba, done_cnt);
        end
    endtask

    task automatic test_error;
        bit ok;
        int bw;
        err_burst = 1; err_beat = 4;
        clear_records();
        pulse_start(32'h4000, 32);
        wait_done(2000, ok);
        settle();
        err_burst = -1; err_beat = -1;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL err_done: no done within budget");
        end
`ifdef WEIGHT_LOADER_RRESP_CHECK_EN
        bw = bad_words(32'h4000, 4);
        tests_run++;
        if (wr_cnt !== 4 || bw !== 0 || beats_total !== 16) begin
            tests_failed++;
            $display("FAIL err_writes: writes=%0d bad=%0d beats=%0d required 4 0 16", wr_cnt, bw, beats_total);
        end
        tests_run++;
        if (ar_addr_q.size() !== 1 || err_at_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_flag: bursts=%0d error=%b required 1 and 1", ar_addr_q.size(), err_at_done);
        end
`else
        bw = bad_words(32'h4000, 32);
        tests_run++;
        if (wr_cnt !== 32 || bw !== 0) begin
            tests_failed++;
            $display("FAIL err_writes: writes=%0d bad=%0d required 32 0", wr_cnt, bw);
        end
        tests_run++;
        if (ar_addr_q.size() !== 2 || err_at_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_flag: bursts=%0d error=%b required 2 and 0", ar_addr_q.size(), err_at_done);
        end
`endif
        clear_records();
        pulse_start(32'h4800, 4);
        wait_done(500, ok);
        settle();
        tests_run++;
        if (!ok || err_at_done !== 1'b0 || wr_cnt !== 4) begin
            tests_failed++;
            $display("FAIL err_clear: done=%0b error=%b writes=%0d required 1 0 4", ok, err_at_done, wr_cnt);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int bw, ba, n;
        logic [31:0] b;
        for (int it = 0; it < 4; it++) begin
            b = 32'h0002_0000 + ($urandom_range(0, 255) << 4);
            n = $urandom_range(1, 100);
            ar_delay = $urandom_range(0, 3);
            clear_records();
            pulse_start(b, n);
            wait_done(3000, ok);
            bw = bad_words(b, n);
            ba = bad_ars(b, n);
            tests_run++;
            if (!ok || bw !== 0 || wr_cnt !== n || ba !== 0 || done_cnt !== 1) begin
                tests_failed++;
                $display("FAIL b2b_%0d: base=%h n=%0d done=%0b bad=%0d writes=%0d bad ars=%0d dones=%0d",
                         it, b, n, ok, bw, wr_cnt, ba, done_cnt);
            end
        end
        ar_delay = 0;
        settle();
    endtask

    initial begin
        clear_records();
        test_reset();
        test_basic();
        test_zero_len();
        test_stall();
        test_clamp();
        test_reset_mid();
        test_error();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
